ex_stage_mc: RTL and testbench
==============================

Name: ex_stage_mc

Overview:
Parametrised execute stage. Successor to the single-cycle EX stage. Computes ALU and multiplier results combinationally and registers them on handoff, like its predecessor. Adds a full request/response handshake to a multi-cycle divider, a pipeline flush with safe draining of in-flight divides, a generic sideband payload, and a forwarding port for the ID stage. Sits between the ID-stage output registers and the MEM stage.

Parameters:
SIDE_W, 48, width of opaque sideband (load_op, dest, gr_we, mem_we, ...) passed through unchanged
RESET_PC, 32'h1c000000, reset value of out_pc
DIV_BYPASS, 0, 1 = a response accepted in S_WAIT hands off the same cycle if out_ready (skips S_HOLD)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
flush  in  1  kill EX contents and out register this cycle
in_valid  in  1  upstream valid; inputs held stable while in_valid & !in_ready
in_ready  out  1  stage can accept
in_pc  in  32  instruction PC
in_alu_op  in  12  alu one-hot op
in_mul_op  in  3  idiot_mul op
in_div_op  in  4  divider op
in_res_sel  in  2  00 alu, 01 mul, 10 div, 11 reserved (treated as alu)
in_src1_is_pc  in  1  src1 = in_pc
in_src2_is_imm  in  1  src2 = in_imm
in_imm, in_rj, in_rkd  in  32 each  operands
in_side  in  SIDE_W  sideband
div_req_valid  out  1  divide request
div_req_ready  in  1  divider accepts
div_req_op  out  4  = in_div_op
div_req_x, div_req_y  out  32 each  = src1, src2
div_resp_valid  in  1  divider result valid
div_resp_ready  out  1  stage accepts result
div_resp_data  in  32  divider result
out_valid  out  1  MEM-stage valid
out_ready  in  1  MEM stage accepts
out_pc, out_result, out_rkd  out  32 each  registered results
out_side  out  SIDE_W  registered sideband
fwd_valid  out  1  EX holds a live instruction
fwd_busy  out  1  fwd_result not yet final (divide pending)
fwd_result  out  32  forwarding value
fwd_side  out  SIDE_W  = in_side

Behaviour:
- Reset (resetn=0 at posedge): state S_IDLE, out_valid 0, out_pc RESET_PC, out_result/out_rkd/out_side/div_buf 0. Reset mid-divide abandons it; the divider is reset by the same resetn.
- src1 = in_src1_is_pc ? in_pc : in_rj; src2 = in_src2_is_imm ? in_imm : in_rkd. comb_res = alu_result | mul_result (existing alu and idiot_mul instances).
- v = in_valid & !flush; is_div = in_res_sel==2'b10.
- FSM states: S_IDLE, S_WAIT, S_HOLD, S_DRAIN.
  - S_IDLE: div_req_valid = v & is_div. On req handshake go to S_WAIT, or to S_DRAIN if flush was raised after a request was accepted. Non-div instructions have ready_go=1 (single cycle).
  - S_WAIT: div_resp_ready=1. On resp_valid capture div_buf <= div_resp_data, then go to S_HOLD. With DIV_BYPASS=1 and out_ready, hand off directly and go to S_IDLE. Flush goes to S_DRAIN; flush together with resp_valid discards the response and goes to S_IDLE.
  - S_HOLD: ready_go=1, result = div_buf. Handoff (out_ready) goes to S_IDLE. Flush goes to S_IDLE.
  - S_DRAIN: div_resp_ready=1, in_ready=0, div_req_valid=0. resp_valid discards the response and goes to S_IDLE.
- ready_go = !is_div | state==S_HOLD | (DIV_BYPASS & state==S_WAIT & div_resp_valid).
- in_ready = resetn & state!=S_DRAIN & (!v | ready_go & out_ready).
- fire = v & ready_go & out_ready. On fire register out_pc, out_result (div value or comb_res), out_rkd, out_side.
- out_valid <= 0 on flush; otherwise, if out_ready, out_valid <= v & ready_go.
- Div request operands are combinational from held inputs. The divider keeps at most one request outstanding. No new request issues until state returns to S_IDLE.
- fwd_valid = v. fwd_busy = v & is_div & state!=S_HOLD. fwd_result = state==S_HOLD ? div_buf : comb_res.
- div_resp_valid in S_IDLE is a protocol error and is ignored (resp_ready=0).

Decomposition:
- Shared package ex_pkg: RES_ALU/RES_MUL/RES_DIV encodings, FSM state enum, RESET_PC constant.
- One natural sub-module: ex_div_ctrl (FSM, div_buf, req/resp handshakes, ready_go, drain). The datapath and output registers stay in ex_stage_mc. alu and idiot_mul are reused as-is.

Test Plan:
- ALU add: rj=5, rkd=7, res_sel=00, out_ready=1 -> out_valid next cycle, out_result=12, in_ready=1 throughout.
- Div with div_req_ready delayed 2 cycles, response 3 cycles later, data=0x11 -> in_ready=0 until handoff, fwd_busy=1 until S_HOLD, then out_result=0x11, exactly one request handshake.
- Backpressure: out_ready=0 for 4 cycles in S_HOLD -> out registers and div_buf stable, no second request; out_ready=1 -> single out_valid pulse.
- Flush in S_WAIT, response arrives 2 cycles later -> S_DRAIN, in_ready=0, response consumed and discarded, out_valid stays 0, then a following ALU op completes normally.
- Flush and div_resp_valid in the same cycle -> response discarded, S_IDLE next cycle, out_valid=0.
- resetn=0 during S_WAIT -> S_IDLE, out_pc=0x1c000000, out_valid=0, div_req_valid=0 next cycle.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings for the multi-cycle execute stage: result-select codes,
// divider-control FSM states and the default reset PC.
package ex_pkg;

  localparam logic [1:0]  RES_ALU      = 2'b00;
  localparam logic [1:0]  RES_MUL      = 2'b01;
  localparam logic [1:0]  RES_DIV      = 2'b10;
  localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } ex_state_e;

endpackage

// File: rtl/alu.sv
// One-hot ALU: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui (pass src2).
module alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);

  logic [4:0]         shamt;
  logic signed [31:0] s1;
  logic signed [31:0] s2;
  logic [31:0]        slt_res;
  logic [31:0]        sltu_res;
  logic [31:0]        sra_res;

  always_comb begin
    shamt    = alu_src2[4:0];
    s1       = $signed(alu_src1);
    s2       = $signed(alu_src2);
    slt_res  = {31'b0, (s1 < s2)};
    sltu_res = {31'b0, (alu_src1 < alu_src2)};
    sra_res  = $unsigned(s1 >>> shamt);
    alu_result = ({32{alu_op[0]}}  & (alu_src1 + alu_src2))
               | ({32{alu_op[1]}}  & (alu_src1 - alu_src2))
               | ({32{alu_op[2]}}  & slt_res)
               | ({32{alu_op[3]}}  & sltu_res)
               | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
               | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
               | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
               | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
               | ({32{alu_op[8]}}  & (alu_src1 << shamt))
               | ({32{alu_op[9]}}  & (alu_src1 >> shamt))
               | ({32{alu_op[10]}} & sra_res)
               | ({32{alu_op[11]}} & alu_src2);
  end

endmodule

// File: rtl/ex_div_ctrl.sv
// Divider handshake controller: request/response tracking, result buffer,
// ready_go generation and draining of divides killed by a flush.
module ex_div_ctrl
  import ex_pkg::*;
#(
  parameter bit DIV_BYPASS = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        v,
  input  logic        is_div,
  input  logic        out_ready,
  input  logic        div_req_ready,
  input  logic        div_resp_valid,
  input  logic [31:0] div_resp_data,
  output logic        div_req_valid,
  output logic        div_resp_ready,
  output logic        ready_go,
  output logic        draining,
  output logic        holding,
  output logic [31:0] div_result,
  output logic [31:0] div_buf
);

  ex_state_e   state_q, state_d;
  logic [31:0] div_buf_q, div_buf_d;
  logic        bypass_hit;

  always_comb begin
    state_d        = state_q;
    div_buf_d      = div_buf_q;
    div_req_valid  = 1'b0;
    div_resp_ready = 1'b0;
    bypass_hit     = DIV_BYPASS && (state_q == S_WAIT) && div_resp_valid;

    case (state_q)
      S_IDLE: begin
        div_req_valid = v & is_div;
        if (div_req_valid && div_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        div_resp_ready = 1'b1;
        if (flush) begin
          // A response landing with the flush is consumed here, otherwise drain it later.
          state_d = div_resp_valid ? S_IDLE : S_DRAIN;
        end else if (div_resp_valid) begin
          div_buf_d = div_resp_data;
          state_d   = (DIV_BYPASS && out_ready) ? S_IDLE : S_HOLD;
        end
      end
      S_HOLD: begin
        if (flush || out_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        div_resp_ready = 1'b1;
        if (div_resp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Nothing may commit while a killed divide is still outstanding.
    ready_go = (state_q != S_DRAIN) && (!is_div || (state_q == S_HOLD) || bypass_hit);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      div_buf_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      div_buf_q <= div_buf_d;
    end
  end

  assign draining   = (state_q == S_DRAIN);
  assign holding    = (state_q == S_HOLD);
  assign div_buf    = div_buf_q;
  assign div_result = holding ? div_buf_q : div_resp_data;

endmodule

// File: rtl/idiot_mul.sv
// Naive single-cycle multiplier: op[0] mul.w (low), op[1] mulh.w (signed high),
// op[2] mulh.wu (unsigned high). Zero result when no op bit is set.
module idiot_mul (
  input  logic [2:0]  mul_op,
  input  logic [31:0] mul_src1,
  input  logic [31:0] mul_src2,
  output logic [31:0] mul_result
);

  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] prod;

  always_comb begin
    // Sign-extend only for mulh.w; the low word is identical either way.
    a    = {{32{mul_op[1] & mul_src1[31]}}, mul_src1};
    b    = {{32{mul_op[1] & mul_src2[31]}}, mul_src2};
    prod = a * b;
    mul_result = ({32{mul_op[0]}} & prod[31:0])
               | ({32{mul_op[1] | mul_op[2]}} & prod[63:32]);
  end

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage: combinational ALU/multiplier, handshaked multi-cycle divider,
// flush with drain, registered MEM-stage outputs and an ID-stage forwarding port.
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int unsigned SIDE_W     = 48,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter bit          DIV_BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [11:0]       in_alu_op,
  input  logic [2:0]        in_mul_op,
  input  logic [3:0]        in_div_op,
  input  logic [1:0]        in_res_sel,
  input  logic              in_src1_is_pc,
  input  logic              in_src2_is_imm,
  input  logic [31:0]       in_imm,
  input  logic [31:0]       in_rj,
  input  logic [31:0]       in_rkd,
  input  logic [SIDE_W-1:0] in_side,
  output logic              div_req_valid,
  input  logic              div_req_ready,
  output logic [3:0]        div_req_op,
  output logic [31:0]       div_req_x,
  output logic [31:0]       div_req_y,
  input  logic              div_resp_valid,
  output logic              div_resp_ready,
  input  logic [31:0]       div_resp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_result,
  output logic [31:0]       out_rkd,
  output logic [SIDE_W-1:0] out_side,
  output logic              fwd_valid,
  output logic              fwd_busy,
  output logic [31:0]       fwd_result,
  output logic [SIDE_W-1:0] fwd_side
);

  logic [31:0]       src1, src2;
  logic [31:0]       alu_result, mul_result, comb_res;
  logic [31:0]       div_result, div_buf;
  logic              v, is_div, ready_go, draining, holding, fire;
  logic              out_valid_q;
  logic [31:0]       out_pc_q, out_result_q, out_rkd_q;
  logic [SIDE_W-1:0] out_side_q;

  assign src1     = in_src1_is_pc  ? in_pc  : in_rj;
  assign src2     = in_src2_is_imm ? in_imm : in_rkd;
  assign v        = in_valid & ~flush;
  assign is_div   = (in_res_sel == RES_DIV);

  alu u_alu (
    .alu_op     (in_alu_op),
    .alu_src1   (src1),
    .alu_src2   (src2),
    .alu_result (alu_result)
  );

  idiot_mul u_mul (
    .mul_op     (in_mul_op),
    .mul_src1   (src1),
    .mul_src2   (src2),
    .mul_result (mul_result)
  );

  // Unselected units are driven with a zero op, so OR-ing acts as the mux.
  assign comb_res = alu_result | mul_result;

  ex_div_ctrl #(
    .DIV_BYPASS (DIV_BYPASS)
  ) u_div_ctrl (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .v              (v),
    .is_div         (is_div),
    .out_ready      (out_ready),
    .div_req_ready  (div_req_ready),
    .div_resp_valid (div_resp_valid),
    .div_resp_data  (div_resp_data),
    .div_req_valid  (div_req_valid),
    .div_resp_ready (div_resp_ready),
    .ready_go       (ready_go),
    .draining       (draining),
    .holding        (holding),
    .div_result     (div_result),
    .div_buf        (div_buf)
  );

  assign div_req_op = in_div_op;
  assign div_req_x  = src1;
  assign div_req_y  = src2;

  assign fire     = v & ready_go & out_ready;
  assign in_ready = resetn & ~draining & (~v | (ready_go & out_ready));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      out_pc_q     <= RESET_PC;
      out_result_q <= 32'h0;
      out_rkd_q    <= 32'h0;
      out_side_q   <= '0;
    end else begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (out_ready) begin
        out_valid_q <= v & ready_go;
      end
      if (fire) begin
        out_pc_q     <= in_pc;
        out_result_q <= is_div ? div_result : comb_res;
        out_rkd_q    <= in_rkd;
        out_side_q   <= in_side;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pc     = out_pc_q;
  assign out_result = out_result_q;
  assign out_rkd    = out_rkd_q;
  assign out_side   = out_side_q;

  assign fwd_valid  = v;
  assign fwd_busy   = v & is_div & ~holding;
  assign fwd_result = holding ? div_buf : comb_res;
  assign fwd_side   = in_side;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Self-checking bench for ex_stage_mc: directed divider/flush/reset scenarios plus
// randomized ALU/multiplier/divider traffic against an arithmetic reference model.
module tb_ex_stage_mc;

  localparam int unsigned SIDE_W = 48;
  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic              clk = 1'b0;
  logic              resetn, flush, in_valid, in_ready;
  logic [31:0]       in_pc, in_imm, in_rj, in_rkd;
  logic [11:0]       in_alu_op;
  logic [2:0]        in_mul_op;
  logic [3:0]        in_div_op, div_req_op;
  logic [1:0]        in_res_sel;
  logic              in_src1_is_pc, in_src2_is_imm;
  logic [SIDE_W-1:0] in_side, out_side, fwd_side;
  logic              div_req_valid, div_req_ready, div_resp_valid, div_resp_ready;
  logic [31:0]       div_req_x, div_req_y, div_resp_data;
  logic              out_valid, out_ready, fwd_valid, fwd_busy;
  logic [31:0]       out_pc, out_result, out_rkd, fwd_result;

  int checks = 0;
  int errors = 0;
  int req_hs = 0;
  int resp_hs = 0;
  logic [31:0] last_res;

  ex_stage_mc #(
    .SIDE_W     (SIDE_W),
    .RESET_PC   (RST_PC),
    .DIV_BYPASS (1'b0)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_alu_op      (in_alu_op),
    .in_mul_op      (in_mul_op),
    .in_div_op      (in_div_op),
    .in_res_sel     (in_res_sel),
    .in_src1_is_pc  (in_src1_is_pc),
    .in_src2_is_imm (in_src2_is_imm),
    .in_imm         (in_imm),
    .in_rj          (in_rj),
    .in_rkd         (in_rkd),
    .in_side        (in_side),
    .div_req_valid  (div_req_valid),
    .div_req_ready  (div_req_ready),
    .div_req_op     (div_req_op),
    .div_req_x      (div_req_x),
    .div_req_y      (div_req_y),
    .div_resp_valid (div_resp_valid),
    .div_resp_ready (div_resp_ready),
    .div_resp_data  (div_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_result     (out_result),
    .out_rkd        (out_rkd),
    .out_side       (out_side),
    .fwd_valid      (fwd_valid),
    .fwd_busy       (fwd_busy),
    .fwd_result     (fwd_result),
    .fwd_side       (fwd_side)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (resetn === 1'b1) begin
      if (div_req_valid === 1'b1 && div_req_ready === 1'b1) req_hs++;
      if (div_resp_valid === 1'b1 && div_resp_ready === 1'b1) resp_hs++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired got no summary want summary");
    $fatal(1);
  end

  // Reference: ALU op index k selects one operation of the one-hot encoding.
  function automatic logic [31:0] alu_model(int unsigned k, logic [31:0] a, logic [31:0] b);
    int signed sa = a;
    int signed sb = b;
    case (k)
      0:  return a + b;
      1:  return a - b;
      2:  return (sa < sb) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return a << b[4:0];
      9:  return a >> b[4:0];
      10: return sa >>> b[4:0];
      default: return b;
    endcase
  endfunction

  function automatic logic [31:0] mul_model(int unsigned k, logic [31:0] a, logic [31:0] b);
    longint          sp = longint'($signed(a)) * longint'($signed(b));
    longint unsigned up = {32'b0, a} * {32'b0, b};
    case (k)
      0:       return sp[31:0];
      1:       return sp[63:32];
      default: return up[63:32];
    endcase
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    in_valid = 1'b0; in_pc = '0; in_alu_op = '0; in_mul_op = '0; in_div_op = '0;
    in_res_sel = '0; in_src1_is_pc = 1'b0; in_src2_is_imm = 1'b0;
    in_imm = '0; in_rj = '0; in_rkd = '0; in_side = '0;
  endtask

  task automatic set_div(input logic [31:0] pc, input logic [3:0] op,
                         input logic [31:0] rj, input logic [31:0] rkd);
    in_pc = pc; in_alu_op = '0; in_mul_op = '0; in_div_op = op; in_res_sel = 2'b10;
    in_src1_is_pc = 1'b0; in_src2_is_imm = 1'b0; in_imm = $urandom;
    in_rj = rj; in_rkd = rkd; in_side = SIDE_W'({$urandom, $urandom});
  endtask

  task automatic rand_comb(output logic [31:0] exp);
    int unsigned k = $urandom_range(0, 14);
    logic [31:0] a, b;
    in_pc = $urandom; in_rj = $urandom; in_rkd = $urandom; in_imm = $urandom;
    if ($urandom_range(0, 3) == 0) in_rkd = in_rj;
    in_src1_is_pc = 1'($urandom_range(0, 1));
    in_src2_is_imm = 1'($urandom_range(0, 1));
    in_div_op = 4'($urandom);
    in_side = SIDE_W'({$urandom, $urandom});
    a = in_src1_is_pc ? in_pc : in_rj;
    b = in_src2_is_imm ? in_imm : in_rkd;
    if (k < 12) begin
      in_alu_op = 12'b1 << k; in_mul_op = '0;
      in_res_sel = (k % 2 == 1) ? 2'b11 : 2'b00;
      exp = alu_model(k, a, b);
    end else begin
      in_alu_op = '0; in_mul_op = 3'b1 << (k - 12); in_res_sel = 2'b01;
      exp = mul_model(k - 12, a, b);
    end
  endtask

  task automatic test_reset;
    set_idle;
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b1;
    div_req_ready = 1'b0; div_resp_valid = 1'b0; div_resp_data = '0;
    repeat (2) step;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_pc !== RST_PC) begin errors++; $display("FAIL reset_out_pc got %h want %h", out_pc, RST_PC); end
    checks++;
    if ({out_result, out_rkd, out_side} !== '0) begin
      errors++; $display("FAIL reset_out_regs got %h %h %h want 0", out_result, out_rkd, out_side);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++;
    if ({div_req_valid, div_resp_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_div_hs got %b want 00", {div_req_valid, div_resp_ready});
    end
    resetn = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_alu_add;
    logic [SIDE_W-1:0] side = 48'h1234_5678_9abc;
    set_idle;
    in_pc = 32'h1c00_0100; in_alu_op = 12'b1; in_rj = 32'd5; in_rkd = 32'd7; in_side = side;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got %b want 1", in_ready); end
    checks++;
    if ({fwd_valid, fwd_busy, fwd_result} !== {2'b10, 32'd12}) begin
      errors++; $display("FAIL add_fwd got %b %b %h want 1 0 c", fwd_valid, fwd_busy, fwd_result);
    end
    checks++;
    if (fwd_side !== side) begin errors++; $display("FAIL add_fwd_side got %h want %h", fwd_side, side); end
    step;
    checks++;
    if ({out_valid, out_result} !== {1'b1, 32'd12}) begin
      errors++; $display("FAIL add_out got %b %h want 1 c", out_valid, out_result);
    end
    checks++;
    if ({out_pc, out_rkd, out_side} !== {32'h1c00_0100, 32'd7, side}) begin
      errors++; $display("FAIL add_out_regs got %h %h %h want 1c000100 7 %h", out_pc, out_rkd, out_side, side);
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL add_idle_in_ready got %b want 1", in_ready); end
    step;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_out_drop got %b want 0", out_valid); end
  endtask

  task automatic test_random_comb;
    logic [31:0] exp, pc_e, rkd_e;
    logic [SIDE_W-1:0] side_e;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      rand_comb(exp);
      pc_e = in_pc; rkd_e = in_rkd; side_e = in_side;
      in_valid = 1'b1;
      #1;
      checks++;
      if ({in_ready, fwd_busy, fwd_result} !== {2'b10, exp}) begin
        errors++; $display("FAIL rand_fwd[%0d] got %b %b %h want 1 0 %h", i, in_ready, fwd_busy, fwd_result, exp);
      end
      step;
      checks++;
      if ({out_valid, out_result} !== {1'b1, exp}) begin
        errors++; $display("FAIL rand_out[%0d] got %b %h want 1 %h", i, out_valid, out_result, exp);
      end
      checks++;
      if ({out_pc, out_rkd, out_side} !== {pc_e, rkd_e, side_e}) begin
        errors++; $display("FAIL rand_regs[%0d] got %h %h %h want %h %h %h",
                           i, out_pc, out_rkd, out_side, pc_e, rkd_e, side_e);
      end
    end
    in_valid = 1'b0;
    step;
  endtask

  task automatic test_div;
    int r0 = req_hs;
    int s0 = resp_hs;
    set_div(32'h1c00_0200, 4'h3, 32'd100, 32'd7);
    div_req_ready = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if ({div_req_valid, div_req_x, div_req_y, div_req_op} !== {1'b1, 32'd100, 32'd7, 4'h3}) begin
      errors++; $display("FAIL div_req got %b %h %h %h want 1 64 7 3", div_req_valid, div_req_x, div_req_y, div_req_op);
    end
    checks++;
    if ({in_ready, fwd_busy} !== 2'b01) begin
      errors++; $display("FAIL div_req_stall got %b want 01", {in_ready, fwd_busy});
    end
    step; step;
    checks++;
    if ({div_req_valid, in_ready} !== 2'b10) begin
      errors++; $display("FAIL div_req_held got %b want 10", {div_req_valid, in_ready});
    end
    div_req_ready = 1'b1;
    step;
    div_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin div_resp_valid = 1'b1; div_resp_data = 32'h11; end
      #1;
      checks++;
      if ({div_req_valid, div_resp_ready, in_ready, fwd_busy, out_valid} !== 5'b01010) begin
        errors++; $display("FAIL div_wait[%0d] got %b want 01010", c,
                           {div_req_valid, div_resp_ready, in_ready, fwd_busy, out_valid});
      end
      step;
    end
    div_resp_valid = 1'b0; div_resp_data = 32'hdead_beef;
    #1;
    checks++;
    if ({fwd_busy, in_ready, out_valid, fwd_result} !== {3'b010, 32'h11}) begin
      errors++; $display("FAIL div_hold got %b %b %b %h want 0 1 0 11", fwd_busy, in_ready, out_valid, fwd_result);
    end
    step;
    checks++;
    if ({out_valid, out_result, out_pc} !== {1'b1, 32'h11, 32'h1c00_0200}) begin
      errors++; $display("FAIL div_out got %b %h %h want 1 11 1c000200", out_valid, out_result, out_pc);
    end
    last_res = 32'h11;
    in_valid = 1'b0;
    step;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL div_out_pulse got %b want 0", out_valid); end
    checks++;
    if (req_hs - r0 != 1 || resp_hs - s0 != 1) begin
      errors++; $display("FAIL div_hs_count got %0d %0d want 1 1", req_hs - r0, resp_hs - s0);
    end
  endtask

  task automatic test_backpressure;
    int r0 = req_hs;
    logic [31:0] d = $urandom;
    set_div($urandom, 4'($urandom), $urandom, $urandom);
    out_ready = 1'b0; div_req_ready = 1'b1; in_valid = 1'b1;
    step;
    div_req_ready = 1'b0; div_resp_valid = 1'b1; div_resp_data = d;
    step;
    div_resp_valid = 1'b0; div_resp_data = ~d;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if ({out_valid, out_result, fwd_result, div_req_valid, in_ready} !== {1'b0, last_res, d, 2'b00}) begin
        errors++; $display("FAIL bp_hold[%0d] got %b %h %h %b %b want 0 %h %h 0 0", c, out_valid,
                           out_result, fwd_result, div_req_valid, in_ready, last_res, d);
      end
      step;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    step;
    checks++;
    if ({out_valid, out_result} !== {1'b1, d}) begin
      errors++; $display("FAIL bp_out got %b %h want 1 %h", out_valid, out_result, d);
    end
    last_res = d;
    in_valid = 1'b0;
    step;
    checks++;
    if ({out_valid, 32'(req_hs - r0)} !== {1'b0, 32'd1}) begin
      errors++; $display("FAIL bp_single got %b %0d want 0 1", out_valid, req_hs - r0);
    end
  endtask

  task automatic test_flush_wait;
    int s0;
    logic [31:0] exp;
    set_div($urandom, 4'($urandom), $urandom, $urandom);
    out_ready = 1'b1; div_req_ready = 1'b1; in_valid = 1'b1;
    step;
    div_req_ready = 1'b0; flush = 1'b1;
    #1;
    checks++;
    if ({fwd_valid, div_resp_ready} !== 2'b01) begin
      errors++; $display("FAIL fw_flush got %b want 01", {fwd_valid, div_resp_ready});
    end
    step;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if ({in_ready, div_req_valid, div_resp_ready, out_valid} !== 4'b0010) begin
      errors++; $display("FAIL fw_drain got %b want 0010", {in_ready, div_req_valid, div_resp_ready, out_valid});
    end
    step;
    s0 = resp_hs;
    div_resp_valid = 1'b1; div_resp_data = $urandom;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL fw_drain2 got %b want 0", in_ready); end
    step;
    div_resp_valid = 1'b0;
    #1;
    checks++;
    if ({in_ready, div_resp_ready, out_valid, 32'(resp_hs - s0)} !== {3'b100, 32'd1}) begin
      errors++; $display("FAIL fw_idle got %b %b %b %0d want 1 0 0 1", in_ready, div_resp_ready,
                         out_valid, resp_hs - s0);
    end
    rand_comb(exp);
    in_valid = 1'b1;
    step;
    checks++;
    if ({out_valid, out_result} !== {1'b1, exp}) begin
      errors++; $display("FAIL fw_next got %b %h want 1 %h", out_valid, out_result, exp);
    end
    in_valid = 1'b0;
    step;
  endtask

  task automatic test_flush_resp;
    int s0;
    logic [31:0] d = $urandom;
    set_div($urandom, 4'($urandom), $urandom, $urandom);
    out_ready = 1'b1; div_req_ready = 1'b1; in_valid = 1'b1;
    step;
    s0 = resp_hs;
    div_req_ready = 1'b0; flush = 1'b1; div_resp_valid = 1'b1; div_resp_data = $urandom;
    step;
    flush = 1'b0; div_resp_valid = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if ({div_resp_ready, in_ready, out_valid, fwd_busy} !== 4'b0100) begin
      errors++; $display("FAIL fr_idle got %b want 0100", {div_resp_ready, in_ready, out_valid, fwd_busy});
    end
    checks++;
    if (resp_hs - s0 != 1) begin errors++; $display("FAIL fr_consumed got %0d want 1", resp_hs - s0); end
    set_div($urandom, 4'($urandom), $urandom, $urandom);
    in_valid = 1'b1;
    #1;
    checks++;
    if (div_req_valid !== 1'b1) begin errors++; $display("FAIL fr_new_req got %b want 1", div_req_valid); end
    div_req_ready = 1'b1;
    step;
    div_req_ready = 1'b0; div_resp_valid = 1'b1; div_resp_data = d;
    step;
    div_resp_valid = 1'b0;
    step;
    checks++;
    if ({out_valid, out_result} !== {1'b1, d}) begin
      errors++; $display("FAIL fr_next got %b %h want 1 %h", out_valid, out_result, d);
    end
    in_valid = 1'b0;
    step;
  endtask

  task automatic test_div_random;
    for (int n = 0; n < 6; n++) begin
      int r0 = req_hs;
      int unsigned dq = $urandom_range(0, 3);
      int unsigned dr = $urandom_range(0, 3);
      int unsigned st = $urandom_range(0, 2);
      logic [31:0] d = $urandom;
      logic [31:0] y_e;
      set_div($urandom, 4'($urandom), $urandom, $urandom);
      in_src2_is_imm = 1'($urandom_range(0, 1));
      y_e = in_src2_is_imm ? in_imm : in_rkd;
      in_valid = 1'b1; out_ready = 1'b1; div_req_ready = 1'b0;
      #1;
      checks++;
      if ({div_req_valid, div_req_y} !== {1'b1, y_e}) begin
        errors++; $display("FAIL drand_req[%0d] got %b %h want 1 %h", n, div_req_valid, div_req_y, y_e);
      end
      repeat (dq) step;
      div_req_ready = 1'b1;
      step;
      div_req_ready = 1'b0;
      repeat (dr) step;
      div_resp_valid = 1'b1; div_resp_data = d; out_ready = (st == 0);
      step;
      div_resp_valid = 1'b0;
      repeat (st) step;
      out_ready = 1'b1;
      step;
      checks++;
      if ({out_valid, out_result, 32'(req_hs - r0)} !== {1'b1, d, 32'd1}) begin
        errors++; $display("FAIL drand_out[%0d] got %b %h %0d want 1 %h 1", n, out_valid, out_result,
                           req_hs - r0, d);
      end
    end
    in_valid = 1'b0;
    step;
  endtask

  task automatic test_reset_mid_div;
    logic [31:0] d = $urandom;
    set_div(32'h1c00_0abc, 4'($urandom), $urandom, $urandom);
    in_valid = 1'b1; out_ready = 1'b1; div_req_ready = 1'b1;
    step;
    div_req_ready = 1'b0; resetn = 1'b0; in_valid = 1'b0;
    step;
    resetn = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_pc, out_result} !== {1'b0, RST_PC, 32'h0}) begin
      errors++; $display("FAIL rst_mid_out got %b %h %h want 0 %h 0", out_valid, out_pc, out_result, RST_PC);
    end
    checks++;
    if ({div_req_valid, div_resp_ready} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_idle got %b want 00", {div_req_valid, div_resp_ready});
    end
    set_div($urandom, 4'($urandom), $urandom, $urandom);
    in_valid = 1'b1;
    #1;
    checks++;
    if (div_req_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_req got %b want 1", div_req_valid); end
    div_req_ready = 1'b1;
    step;
    div_req_ready = 1'b0; div_resp_valid = 1'b1; div_resp_data = d;
    step;
    div_resp_valid = 1'b0;
    step;
    checks++;
    if ({out_valid, out_result} !== {1'b1, d}) begin
      errors++; $display("FAIL rst_mid_next got %b %h want 1 %h", out_valid, out_result, d);
    end
    in_valid = 1'b0;
    step;
  endtask

  initial begin
    last_res = '0;
    test_reset;
    test_alu_add;
    test_random_comb;
    test_div;
    test_backpressure;
    test_flush_wait;
    test_flush_resp;
    test_div_random;
    test_reset_mid_div;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
